triple_loader: RTL and testbench

Stream-to-triple operand loader for the FFT datapath. It collects a serial stream of N-bit samples under a valid/ready handshake and groups them into parallel A/B/C operand triples. A triple is held stable under a valid/ready handshake until the downstream three-input registered adder stage accepts it. The block is the producer end of that adder's operand interface, and it keeps accepting samples while a triple is waiting.

---
 rtl/fft_pkg.sv | 11 +
 rtl/triple_loader.sv | 131 +++++++++++++
 tb/tb_triple_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions.
// Sample width default and loader fill-state encodings.
package fft_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

endpackage

// File: rtl/triple_loader.sv
// Stream-to-triple operand loader feeding the three-input adder.
// Optional partial-triple flush: define TRIPLE_LOADER_FLUSH_EN.
module triple_loader
  import fft_pkg::*;
#(
  parameter int N = SAMPLE_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_A,
  output logic [N-1:0] o_B,
  output logic [N-1:0] o_C,
  output logic         o_valid,
  input  logic         i_ready
`ifdef TRIPLE_LOADER_FLUSH_EN
  ,
  input  logic         i_flush
`endif
);

  logic [1:0]   cnt_q, cnt_d;
  logic [N-1:0] s0_q, s0_d;
  logic [N-1:0] s1_q, s1_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] c_q, c_d;
  logic         vld_q, vld_d;

  logic slot_free;
  logic accept;
  logic drain;

  assign slot_free = !(vld_q && !i_ready);
  assign o_ready   = !(cnt_q == TWO && !slot_free);
  assign accept    = i_valid && o_ready;
  assign drain     = vld_q && i_ready;

  assign o_A     = a_q;
  assign o_B     = b_q;
  assign o_C     = c_q;
  assign o_valid = vld_q;

  // Next-state: stage samples, load a full triple, retire on drain.
  always_comb begin
    cnt_d = cnt_q;
    s0_d  = s0_q;
    s1_d  = s1_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    vld_d = vld_q;
    if (drain) begin
      vld_d = 1'b0;
    end
    if (accept) begin
      case (cnt_q)
        EMPTY: begin
          s0_d  = i_data;
          cnt_d = ONE;
        end
        ONE: begin
          s1_d  = i_data;
          cnt_d = TWO;
        end
        default: begin
          a_d   = s0_q;
          b_d   = s1_q;
          c_d   = i_data;
          vld_d = 1'b1;
          cnt_d = EMPTY;
        end
      endcase
    end
`ifdef TRIPLE_LOADER_FLUSH_EN
    // Flush emits whatever is staged, zero-padded; a third-sample
    // accept is already a full load and needs no special handling.
    if (i_flush && slot_free && !(accept && cnt_q == TWO)) begin
      case (cnt_q)
        EMPTY: begin
          if (accept) begin
            a_d   = i_data;
            b_d   = '0;
            c_d   = '0;
            vld_d = 1'b1;
            cnt_d = EMPTY;
          end
        end
        ONE: begin
          a_d   = s0_q;
          b_d   = accept ? i_data : '0;
          c_d   = '0;
          vld_d = 1'b1;
          cnt_d = EMPTY;
        end
        default: begin
          a_d   = s0_q;
          b_d   = s1_q;
          c_d   = '0;
          vld_d = 1'b1;
          cnt_d = EMPTY;
        end
      endcase
    end
`endif
  end

  // State registers; reset discards any partially staged triple.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= EMPTY;
      s0_q  <= '0;
      s1_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: tb/tb_triple_loader.sv
// Scoreboard bench for triple_loader.
// Directed vectors; monitor checks every handshaked triple.
module tb_triple_loader;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } trip_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] o_A, o_B, o_C;
  logic        o_valid;
  logic        i_ready = 1'b1;
`ifdef TRIPLE_LOADER_FLUSH_EN
  logic        i_flush = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  trip_t exp_q[$];
  logic stream_on = 1'b0;
  logic ready_drop = 1'b0;
  int   vcnt = 0;

  triple_loader #(.N(16)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_A     (o_A),
    .o_B     (o_B),
    .o_C     (o_C),
    .o_valid (o_valid),
    .i_ready (i_ready)
`ifdef TRIPLE_LOADER_FLUSH_EN
    ,
    .i_flush (i_flush)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare each accepted triple against the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (stream_on) begin
        if (!o_ready) ready_drop = 1'b1;
        if (o_valid) vcnt++;
      end
      if (o_valid && i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_triple: got %h %h %h expected none",
                   o_A, o_B, o_C);
        end else begin
          trip_t e;
          e = exp_q.pop_front();
          if (o_A !== e.a || o_B !== e.b || o_C !== e.c) begin
            errors++;
            $display("FAIL triple: got %h %h %h expected %h %h %h",
                     o_A, o_B, o_C, e.a, e.b, e.c);
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    i_valid = 1'b1;
    i_data  = d;
    forever begin
      @(negedge i_clk);
      if (o_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got o_ready=0 expected 1 data %h", d);
        break;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c);
    trip_t t;
    t.a = a;
    t.b = b;
    t.c = c;
    exp_q.push_back(t);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_valid", {15'd0, o_valid}, 16'd0);
    chk("rst_ready", {15'd0, o_ready}, 16'd1);
    chk("rst_A", o_A, 16'h0);
    chk("rst_B", o_B, 16'h0);
    chk("rst_C", o_C, 16'h0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Reset mid-fill discards staged samples
    send(16'h0011);
    send(16'h0022);
    i_valid = 1'b0;
    i_rst = 1'b1;
    #2;
    chk("midrst_valid", {15'd0, o_valid}, 16'd0);
    chk("midrst_ready", {15'd0, o_ready}, 16'd1);
    chk("midrst_A", o_A, 16'h0);
    chk("midrst_C", o_C, 16'h0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    push(16'h1, 16'h2, 16'h3);
    send(16'h1);
    send(16'h2);
    send(16'h3);
    idle(3);

    // Streaming 1..9 with i_ready high
    stream_on = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i % 3 == 0)
        push(16'(i - 2), 16'(i - 1), 16'(i));
      send(16'(i));
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    stream_on = 1'b0;
    chk("stream_ready_drop", {15'd0, ready_drop}, 16'd0);
    chk("stream_valid_cycles", 16'(vcnt), 16'd3);
    idle(2);

    // Full-scale values pass bit-exact
    push(16'hFFFF, 16'h8000, 16'h7FFF);
    send(16'hFFFF);
    send(16'h8000);
    send(16'h7FFF);
    idle(3);

    // Backpressure, then simultaneous drain and load
    i_ready = 1'b0;
    push(16'hAAAA, 16'hBBBB, 16'hCCCC);
    send(16'hAAAA);
    send(16'hBBBB);
    send(16'hCCCC);
    send(16'h1111);
    send(16'h2222);
    i_valid = 1'b1;
    i_data  = 16'h3333;
    @(negedge i_clk);
    chk("bp_ready", {15'd0, o_ready}, 16'd0);
    chk("bp_valid", {15'd0, o_valid}, 16'd1);
    chk("bp_held_A", o_A, 16'hAAAA);
    repeat (2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("bp_held_C", o_C, 16'hCCCC);
    chk("bp_still_stalled", {15'd0, o_ready}, 16'd0);
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    push(16'h1111, 16'h2222, 16'h3333);
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    i_valid = 1'b0;
    chk("swap_valid", {15'd0, o_valid}, 16'd1);
    chk("swap_A", o_A, 16'h1111);
    chk("swap_C", o_C, 16'h3333);
    i_ready = 1'b1;
    idle(3);

`ifdef TRIPLE_LOADER_FLUSH_EN
    // Flush with a coincident accept yields a partial triple
    push(16'h0005, 16'h0006, 16'h0000);
    send(16'h0005);
    i_valid = 1'b1;
    i_data  = 16'h0006;
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_valid", {15'd0, o_valid}, 16'd1);
    chk("flush_B", o_B, 16'h0006);
    idle(2);
    // Flush with nothing staged is a no-op
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    chk("flush_empty_valid", {15'd0, o_valid}, 16'd0);
    idle(2);
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d pending expected 0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
